// File: rtl/cpu_pkg.sv
// Purpose : shared widths, HALT opcode and the fetch entry type for the fetch slice.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: WORD_W/ADDR_W widths, HALT_OPC, fetch_entry_t {pc, instr}, is_halt() helper.
package cpu_pkg;

  localparam int          WORD_W   = 16;
  localparam int          ADDR_W   = 16;
  localparam logic [3:0]  HALT_OPC = 4'hF;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // Opcode lives in the top nibble of the instruction word.
  function automatic logic is_halt(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 4] == HALT_OPC;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Purpose : bundles the ROM port, the execute redirect and the decode handshake of fetch.
// Latency : n/a (wires only).
// Backpr. : inst_ready from decode stalls the head entry; master = fetch, slave = ROM/decode/execute.
// Signals : counter/instruction (ROM), redirect_valid/redirect_pc (execute),
//           inst_valid/inst_data/inst_pc/inst_ready (decode), halted (status).
interface instruction_fetch_if
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = ADDR_W
);

  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_ready;
  logic                  halted;

  modport master (
    output counter, inst_valid, inst_data, inst_pc, halted,
    input  instruction, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  counter, inst_valid, inst_data, inst_pc, halted,
    output instruction, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Purpose : synchronous prefetch FIFO of fetch entries with push/pop/flush.
// Latency : a push is visible at the head one cycle later; head is read combinationally.
// Backpr. : caller must not push when full unless popping, nor pop when empty.
// Ports   : clk, rst (sync, active high), push/push_dat, pop, flush, head_dat, full, empty.
//           Flush beats push; a pop in the flush cycle is simply absorbed by the flush.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_dat,
  input  logic   pop,
  input  logic   flush,
  output entry_t head_dat,
  output logic   full,
  output logic   empty
);

  // DEPTH is a power of two, so pointers wrap naturally.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Push into a full FIFO only happens alongside a pop, and then wr_ptr == rd_ptr:
  // the slot overwritten is exactly the head being consumed this cycle.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Purpose : fetch initiator: owns the PC, reads the ROM, buffers {pc, instr} for decode.
// Latency : first push on the first cycle out of reset, inst_valid one cycle later;
//           a redirect in cycle N yields the target entry at the head in cycle N+2.
// Backpr. : inst_ready low with a full FIFO stops pushes and holds the PC.
// Ports   : clk, rst (sync, active high), bus (instruction_fetch_if.master).
// Config  : IFETCH_HALT_EN defined -> a pushed HALT word (top nibble HALT_OPC) stops fetch
//           until a redirect or reset; undefined -> halted tied to 0, fetch never stops.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = WORD_W,
  parameter int                    ADDR_WIDTH = ADDR_W,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.master  bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  halted;
  logic                  halt_word;
  entry_t                push_dat;
  entry_t                head_dat;

  // Redirect target LSB is ignored: instructions are always half-word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = bus.redirect_pc[0];

  assign pop  = !empty && bus.inst_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign push = !bus.redirect_valid && !halted && (!full || pop);

  assign push_dat.pc    = pc;
  assign push_dat.instr = bus.instruction;

`ifdef IFETCH_HALT_EN
  assign halt_word = (bus.instruction[DATA_WIDTH-1 -: 4] == HALT_OPC);

  always_ff @(posedge clk) begin
    if (rst)                     halted <= 1'b0;
    else if (bus.redirect_valid) halted <= 1'b0;
    else if (push && halt_word)  halted <= 1'b1;
  end
`else
  assign halt_word = 1'b0;
  assign halted    = 1'b0;
`endif

  // The PC stays on the HALT word so that a later resume-by-redirect is the only exit.
  always_ff @(posedge clk) begin
    if (rst)                     pc <= {RESET_PC[ADDR_WIDTH-1:1], 1'b0};
    else if (bus.redirect_valid) pc <= {bus.redirect_pc[ADDR_WIDTH-1:1], 1'b0};
    else if (push && !halt_word) pc <= pc + ADDR_WIDTH'(2);
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  assign bus.counter    = pc;
  assign bus.inst_valid = !empty;
  assign bus.inst_data  = head_dat.instr;
  assign bus.inst_pc    = head_dat.pc;
  assign bus.halted     = halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose : directed bench for instruction_fetch with a queue-based reference model.
// Latency : model advances on posedge; DUT outputs compared on every negedge.
// Backpr. : inst_ready is driven from the directed sequence below.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef IFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic halt_rom = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // ROM: word i = 1000+i for i=0..14; word 3 becomes a HALT when halt_rom is set.
  function automatic logic [15:0] rom(input logic [15:0] addr, input logic hr);
    logic [14:0] idx;
    idx = addr[15:1];
    if (hr && idx == 15'd3) return 16'hF000;
    if (idx < 15'd15)       return 16'h1000 + {1'b0, idx};
    return 16'h2000 | {4'h0, idx[11:0]};
  endfunction

  always_comb bus.instruction = rom(bus.counter, halt_rom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: decode-visible queue of {pc, instr}, fetch pointer and halt flag.
  logic [31:0] mq[$];
  logic [15:0] mpc;
  logic        mhalt;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    bit          do_pop;
    bit          do_push;
    logic [15:0] w;
    if (rst) begin
      mq.delete();
      mpc      = RST_PC;
      mhalt    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      do_pop  = (mq.size() > 0) && bus.inst_ready;
      do_push = !bus.redirect_valid && !mhalt && ((mq.size() < DEPTH) || do_pop);
      w       = rom(mpc, halt_rom);
      if (do_pop) void'(mq.pop_front());
      if (bus.redirect_valid) begin
        mq.delete();
        mpc   = bus.redirect_pc & 16'hFFFE;
        mhalt = 1'b0;
      end else if (do_push) begin
        mq.push_back({mpc, w});
        if (HALT_EN && w[15:12] == 4'hF) mhalt = 1'b1;
        else                             mpc   = mpc + 16'd2;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_counter", 32'(bus.counter), 32'(mpc));
      check("m_valid", 32'(bus.inst_valid), 32'(mq.size() > 0));
      check("m_halted", 32'(bus.halted), 32'(mhalt));
      if (mq.size() > 0) begin
        check("m_inst_pc", 32'(bus.inst_pc), 32'(mq[0][31:16]));
        check("m_inst_data", 32'(bus.inst_data), 32'(mq[0][15:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    repeat (2) step();
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_counter", 32'(bus.counter), 32'h0000);
    check("rst_halted", 32'(bus.halted), 32'd0);

    // Decode stalled from reset release: FIFO fills to two, PC parks at 4.
    rst = 1'b0;
    repeat (5) step();
    check("stall_counter", 32'(bus.counter), 32'h0004);
    check("stall_valid", 32'(bus.inst_valid), 32'd1);
    check("stall_head_pc", 32'(bus.inst_pc), 32'h0000);
    check("stall_head_data", 32'(bus.inst_data), 32'h1000);
    bus.inst_ready = 1'b1;
    step();
    check("drain_pc2", 32'(bus.inst_pc), 32'h0002);
    step();
    check("drain_pc4", 32'(bus.inst_pc), 32'h0004);
    check("drain_data4", 32'(bus.inst_data), 32'h1002);

    // Redirect while full with a same-cycle pop; target LSB dropped.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0013;
    step();
    bus.redirect_valid = 1'b0;
    check("redir_valid", 32'(bus.inst_valid), 32'd0);
    check("redir_counter", 32'(bus.counter), 32'h0012);
    step();
    check("redir_pc", 32'(bus.inst_pc), 32'h0012);
    check("redir_data", 32'(bus.inst_data), 32'h1009);

    // PC wrap from FFFE to 0.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    step();
    bus.redirect_valid = 1'b0;
    check("wrap_counter0", 32'(bus.counter), 32'hFFFE);
    step();
    check("wrap_pc", 32'(bus.inst_pc), 32'hFFFE);
    check("wrap_data", 32'(bus.inst_data), 32'h2FFF);
    check("wrap_counter", 32'(bus.counter), 32'h0000);
    step();
    check("wrap_next_pc", 32'(bus.inst_pc), 32'h0000);

    // Mid-stream reset with two entries buffered, then the free-running sequence.
    bus.inst_ready = 1'b0;
    repeat (2) step();
    check("pre_rst_counter", 32'(bus.counter), 32'h0004);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
    check("mid_rst_counter", 32'(bus.counter), 32'h0000);
    rst            = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    check("seq_pc0", 32'(bus.inst_pc), 32'h0000);
    check("seq_data0", 32'(bus.inst_data), 32'h1000);
    check("seq_counter", 32'(bus.counter), 32'h0002);
    step();
    check("seq_pc1", 32'(bus.inst_pc), 32'h0002);
    check("seq_data1", 32'(bus.inst_data), 32'h1001);
    step();
    check("seq_pc2", 32'(bus.inst_pc), 32'h0004);
    check("seq_data2", 32'(bus.inst_data), 32'h1002);

`ifdef IFETCH_HALT_EN
    // HALT at word 3: entries 0..3 drain, fetch parks on 6 until redirected.
    rst      = 1'b1;
    halt_rom = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_counter", 32'(bus.counter), 32'h0006);
    check("halt_valid", 32'(bus.inst_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0000;
    step();
    bus.redirect_valid = 1'b0;
    check("resume_halted", 32'(bus.halted), 32'd0);
    check("resume_counter", 32'(bus.counter), 32'h0000);
    step();
    check("resume_pc", 32'(bus.inst_pc), 32'h0000);
    repeat (4) step();
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
